// File: rtl/rf_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Holds default sizes, address/data typedefs and the zero-register index.
package rf_pkg;

    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_NR    = 2;
    localparam int RF_NW    = 2;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    localparam int unsigned RF_ZERO_IDX = 0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: write bypass, zero/range masking, ready.
// Ports: addr_i, wr_ok_i/wr_addr_i/wr_data_i (qualified writes),
//        mem_data_i/pend_i (stored entry), data_o, ready_o.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NW       = RF_NW,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic [AW-1:0]    addr_i,
    input  logic [NW-1:0]    wr_ok_i,
    input  logic [NW*AW-1:0] wr_addr_i,
    input  logic [NW*DW-1:0] wr_data_i,
    input  logic [DW-1:0]    mem_data_i,
    input  logic             pend_i,
    output logic [DW-1:0]    data_o,
    output logic             ready_o
);

    logic          hit;
    logic [DW-1:0] byp;
    logic          masked;

    // Later ports overwrite earlier hits, so the highest index wins.
    always_comb begin
        hit = 1'b0;
        byp = '0;
        for (int j = 0; j < NW; j++) begin
            if (wr_ok_i[j] && wr_addr_i[j*AW +: AW] == addr_i) begin
                hit = 1'b1;
                byp = wr_data_i[j*DW +: DW];
            end
        end
    end

    assign masked = (32'(addr_i) >= 32'(DEPTH))
                  || (ZERO_REG != 0 && addr_i == AW'(RF_ZERO_IDX));

    always_comb begin
        data_o  = mem_data_i;
        ready_o = !pend_i;
        if (masked) begin
            data_o  = '0;
            ready_o = 1'b1;
        end else if (hit) begin
            data_o  = byp;
            ready_o = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-through bypass and pending scoreboard.
// Ports: clk_i, rst_n_i, rd_addr_i/rd_data_o/rd_ready_o (NR reads),
//        wr_en_i/wr_addr_i/wr_data_i (NW writes), rsv_en_i/rsv_addr_i, flush_i.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NR       = RF_NR,
    parameter int NW       = RF_NW,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [NR*AW-1:0] rd_addr_i,
    output logic [NR*DW-1:0] rd_data_o,
    output logic [NR-1:0]    rd_ready_o,
    input  logic [NW-1:0]    wr_en_i,
    input  logic [NW*AW-1:0] wr_addr_i,
    input  logic [NW*DW-1:0] wr_data_i,
    input  logic             rsv_en_i,
    input  logic [AW-1:0]    rsv_addr_i,
    input  logic             flush_i
);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [NW-1:0]    wr_ok;
    logic             rsv_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < 32'(DEPTH))
            && !(ZERO_REG != 0 && a == AW'(RF_ZERO_IDX));
    endfunction

    // Gating with reset keeps the bypass from leaking data while in reset.
    always_comb begin
        wr_ok = '0;
        for (int j = 0; j < NW; j++) begin
            wr_ok[j] = wr_en_i[j] && rst_n_i
                    && addr_ok(wr_addr_i[j*AW +: AW]);
        end
        rsv_ok = rsv_en_i && addr_ok(rsv_addr_i);
    end

    // Order matters: writes clear, reserve re-sets, flush clears everything.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        for (int j = 0; j < NW; j++) begin
            if (wr_ok[j]) begin
                mem_d[wr_addr_i[j*AW +: AW]]  = wr_data_i[j*DW +: DW];
                pend_d[wr_addr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_ok) begin
            pend_d[rsv_addr_i] = 1'b1;
        end
        if (flush_i) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q  <= '{default: '0};
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          in_rng;
        logic [DW-1:0] mem_rd;
        logic          pend_rd;

        assign ra      = rd_addr_i[k*AW +: AW];
        assign in_rng  = 32'(ra) < 32'(DEPTH);
        assign mem_rd  = in_rng ? mem_q[ra] : '0;
        assign pend_rd = in_rng && pend_q[ra];

        rf_read_port #(
            .DW       (DW),
            .DEPTH    (DEPTH),
            .NW       (NW),
            .ZERO_REG (ZERO_REG),
            .AW       (AW)
        ) u_port (
            .addr_i     (ra),
            .wr_ok_i    (wr_ok),
            .wr_addr_i  (wr_addr_i),
            .wr_data_i  (wr_data_i),
            .mem_data_i (mem_rd),
            .pend_i     (pend_rd),
            .data_o     (rd_data_o[k*DW +: DW]),
            .ready_o    (rd_ready_o[k])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (DEPTH=32 and DEPTH=24 instances).
// Both instances share all inputs; outputs are checked separately.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data24;
    logic [1:0]  rd_ready, rd_ready24;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_scoreboard u_dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_ready_o (rd_ready),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .flush_i    (flush)
    );

    regfile_scoreboard #(.DEPTH(24)) u_d24 (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data24),
        .rd_ready_o (rd_ready24),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .flush_i    (flush)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start a new cycle with everything idle; caller then sets fields.
    task automatic cyc(input logic [4:0] a1, input logic [4:0] a0);
        @(negedge clk);
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        rsv_en  = 1'b0;
        rsv_addr = '0;
        flush   = 1'b0;
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input int p, input logic [4:0] a,
                      input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = {5'd0, 5'd5};
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
        #12;
        chk("reset_data", rd_data, 64'h0);
        chk("reset_ready", {62'h0, rd_ready}, 64'h3);

        cyc(5'd0, 5'd5);
        rst_n = 1'b1;

        // Bypass then stored value
        cyc(5'd0, 5'd7);
        wr(0, 5'd7, 32'h1234);
        #1;
        chk("r7_bypass", rd_data[31:0], 64'h1234);
        chk("r7_byp_rdy", rd_ready, 64'h3);
        cyc(5'd0, 5'd7);
        #1;
        chk("r7_mem", rd_data[31:0], 64'h1234);
        chk("r7_mem_d24", rd_data24[31:0], 64'h1234);

        // Same-address dual write: highest port wins
        cyc(5'd4, 5'd0);
        wr(0, 5'd4, 32'hAAAA);
        wr(1, 5'd4, 32'hBBBB);
        #1;
        chk("r4_bypass", rd_data[63:32], 64'hBBBB);
        cyc(5'd0, 5'd4);
        #1;
        chk("r4_mem", rd_data[31:0], 64'hBBBB);

        // Reserve r9, writeback three cycles later
        cyc(5'd0, 5'd9);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        #1;
        chk("r9_rsv_same", rd_ready, 64'h3);
        cyc(5'd0, 5'd9);
        #1;
        chk("r9_pend1", rd_ready, 64'h2);
        cyc(5'd0, 5'd9);
        #1;
        chk("r9_pend2", rd_ready, 64'h2);
        cyc(5'd0, 5'd9);
        wr(1, 5'd9, 32'h55);
        #1;
        chk("r9_wb_data", rd_data[31:0], 64'h55);
        chk("r9_wb_rdy", rd_ready, 64'h3);
        cyc(5'd0, 5'd9);
        #1;
        chk("r9_after", {rd_ready, rd_data[31:0]}, {32'h3, 32'h55});

        // Reserve beats write; flush beats reserve
        cyc(5'd0, 5'd2);
        wr(0, 5'd2, 32'h22);
        rsv_en = 1'b1; rsv_addr = 5'd2;
        cyc(5'd0, 5'd2);
        #1;
        chk("r2_pend", {rd_ready, rd_data[31:0]}, {32'h2, 32'h22});
        cyc(5'd6, 5'd2);
        flush = 1'b1;
        rsv_en = 1'b1; rsv_addr = 5'd6;
        #1;
        chk("flush_same", rd_ready, 64'h2);
        cyc(5'd6, 5'd2);
        #1;
        chk("flush_after", rd_ready, 64'h3);

        // Zero register
        cyc(5'd0, 5'd0);
        wr(0, 5'd0, 32'hFFFF);
        rsv_en = 1'b1; rsv_addr = 5'd0;
        #1;
        chk("r0_same", {rd_ready, rd_data}, {62'h3, 64'h0});
        cyc(5'd0, 5'd0);
        #1;
        chk("r0_after", {rd_ready, rd_data}, {62'h3, 64'h0});

        // Out-of-range address on DEPTH=24
        cyc(5'd30, 5'd30);
        wr(1, 5'd30, 32'h77);
        rsv_en = 1'b1; rsv_addr = 5'd30;
        #1;
        chk("oor_same", {rd_ready24, rd_data24}, {62'h3, 64'h0});
        chk("r30_d32_byp", rd_data[31:0], 64'h77);
        cyc(5'd30, 5'd30);
        #1;
        chk("oor_after", {rd_ready24, rd_data24}, {62'h3, 64'h0});
        chk("r30_d32_pend", rd_ready, 64'h0);

        // Mid-cycle reset discards state and the in-flight write
        cyc(5'd0, 5'd3);
        wr(0, 5'd3, 32'hDEAD);
        cyc(5'd7, 5'd3);
        rsv_en = 1'b1; rsv_addr = 5'd11;
        #1;
        chk("r3_mem", rd_data, {32'h1234, 32'hDEAD});
        wr(1, 5'd3, 32'hBEEF);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data", rd_data, 64'h0);
        chk("rst_mid_rdy", rd_ready, 64'h3);
        cyc(5'd11, 5'd3);
        rst_n = 1'b1;
        #1;
        chk("post_rst", {rd_ready, rd_data}, {62'h3, 64'h0});

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-port register file with write-through bypass and a per-register pending-write scoreboard. It supersedes the fixed 32x32, 2-read/1-write file in the decode stage. It supplies operand data plus an operand-ready flag to the hazard unit, so load-use and multi-cycle stalls come from `rd_ready_o` instead of address comparators scattered through the pipeline.

## Interface
- `DW`, 32, data width in bits
- `DEPTH`, 32, number of architectural registers
- `NR`, 2, number of read ports
- `NW`, 2, number of write ports
- `ZERO_REG`, 1, 1 = register 0 hardwired to zero, never written, never pending
- `AW`, derived `$clog2(DEPTH)`, address width; not overridable

Ports:
- `clk_i` in 1: the single clock; all state updates on its rising edge
- `rst_n_i` in 1: asynchronous, active-low reset
- `rd_addr_i` in NR*AW: read addresses; port k uses slice [k*AW +: AW]
- `rd_data_o` out NR*DW: read data, combinational
- `rd_ready_o` out NR: 1 when the operand value on `rd_data_o` is final
- `wr_en_i` in NW: write enables
- `wr_addr_i` in NW*AW: write addresses
- `wr_data_i` in NW*DW: write data
- `rsv_en_i` in 1: reserve a destination (an instruction issued that will write later)
- `rsv_addr_i` in AW: register being reserved
- `flush_i` in 1: synchronous clear of all pending bits (pipeline flush)

## Operation
- Storage: `mem[DEPTH]` of DW bits, plus a `pend[DEPTH]` bit vector.
- Write, at posedge: for each port j with `wr_en_i[j]`, `mem[wr_addr_i[j]]` takes `wr_data_i[j]`.
  - If several ports target the same address, the highest index j wins.
  - Each valid write also clears `pend` of that address.
- Reserve, at posedge: if `rsv_en_i`, set `pend[rsv_addr_i]`.
  - Reserve plus write to the same address in the same cycle: the reserve wins, so `pend` stays 1. A new producer supersedes the old one; the data is still written.
- Flush: if `flush_i`, all `pend` bits are cleared at posedge.
  - Flush has priority over a reserve in the same cycle; that reservation is dropped.
  - Writes in a flush cycle still update `mem`.
- Read port k, combinational:
  - If any `wr_en_i[j]` has `wr_addr_i[j] == rd_addr_i[k]`, the output is the data of the highest such j. This is the bypass, and `rd_ready_o[k]` is 1.
  - Otherwise the output is `mem[addr]`, and `rd_ready_o[k]` = `!pend[addr]`.
- Reservation is never bypassed: a same-cycle `rsv_en_i` does not affect `rd_ready_o` until the next cycle.
- ZERO_REG=1, address 0:
  - Writes are ignored and reserves are ignored.
  - Reads return 0 with ready 1, including the bypass path.
- Out-of-range address (>= DEPTH, only when DEPTH is not a power of 2):
  - Writes and reserves are ignored.
  - Reads return 0 with ready 1.
- Reset (`rst_n_i` low, asynchronous):
  - All `mem` entries are 0 and all `pend` bits are 0.
  - Outputs immediately show `rd_data_o` = 0 and `rd_ready_o` = all 1s.
  - A reset asserted mid-cycle discards that cycle's writes and reserves.

## Timing
- Write-to-read latency: 0 cycles via the bypass; the value persists in `mem` from the next cycle.
- Reserve-to-not-ready latency: 1 cycle.
- Pending clear: the writeback cycle itself shows ready=1 via the bypass; the next cycle shows ready=1 from `pend`.
- Combinational path: address compare, then priority mux, then output. There are no registered outputs.
- Reset release: the first capturing edge is the first posedge after `rst_n_i` rises. The upstream reset synchroniser guarantees release timing.

## Structure
- The shared package `rf_pkg` holds:
  - the default DW/DEPTH/NR/NW constants
  - the `rf_addr_t`/`rf_data_t` typedefs, sized from those defaults
  - the zero-register index constant
- One natural sub-module is `rf_read_port`. It is instantiated NR times and holds:
  - the bypass priority compare over NW write ports
  - the ZERO_REG and range masking
  - the ready computation
- Storage, scoreboard and reset stay in the top module.

## Test plan
- Reset → `rd_addr_i`={5,0} gives `rd_data_o`=0 on both ports and `rd_ready_o`=2'b11. Assert reset mid-run after writing r3=0xDEAD → r3 reads 0 immediately.
- Write r7=0x1234 on port 0 → the same-cycle read of r7 returns 0x1234, ready=1; the next cycle returns 0x1234 from `mem`.
- Same cycle: port0 writes r4=0xAAAA and port1 writes r4=0xBBBB → the bypass read gives 0xBBBB, and r4 holds 0xBBBB afterwards.
- Reserve r9 → the next cycle r9 ready=0. Write r9=0x55 three cycles later → ready=1 with data 0x55 in that cycle, and `pend` is clear after it.
- Reserve r2 together with a write to r2 in the same cycle → r2 ready=0 next cycle. Then `flush_i` together with a reserve of r6 → both r2 and r6 are ready=1 next cycle.
- ZERO_REG=1: write r0=0xFFFF and reserve r0 → r0 reads 0, ready=1, both in the same cycle and afterwards. Repeat with DEPTH=24: address 30 reads 0, ready=1, and a write to it is ignored.
